seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl_pkg.sv | 22 ++
 rtl/seg_scan_ctrl_tick.sv | 31 +++
 rtl/seg_scan_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 506 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the
// multiplexed 7-segment scan controller.
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  // Codes 10-15 decode to all segments off
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  // Map any non-BCD nibble to the blank code
  function automatic logic [3:0] bcd_clean(
    input logic [3:0] nib
  );
    return (nib > BCD_MAX) ? BLANK_CODE : nib;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_tick.sv
// Slot counter for the scan controller:
// counts 0..SCAN_DIV-1 and flags the slot end.
module scan_tick_gen #(
  parameter int SCAN_DIV = 50000,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          slot_end
);

  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  // Slot end is only meaningful while running
  assign slot_end = run & (count == LAST);

  // Free-running slot counter with sync clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (run) begin
      count <= slot_end ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with
// shadowed display load and leading-zero blanking.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    lzb,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic                    load_ready,
  output logic                    load_err,
  output logic [3:0]              digit_bcd,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [CW-1:0] BLANK_LAST =
    CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(NUM_DIGITS - 1);

  scan_state_t state_q;
  scan_state_t state_d;

  logic [IW-1:0]         idx_q;
  logic [IW-1:0]         idx_d;
  logic [CW-1:0]         count;
  logic                  slot_end;
  logic                  cnt_clr;

  logic [DW-1:0]         disp_q;
  logic [DW-1:0]         disp_d;
  logic [NUM_DIGITS-1:0] ddp_q;
  logic [NUM_DIGITS-1:0] ddp_d;
  logic [DW-1:0]         shad_q;
  logic [NUM_DIGITS-1:0] shdp_q;
  logic                  pend;

  logic                  capture;
  logic                  commit;
  logic                  wrap;
  logic [DW-1:0]         clean;
  logic                  bad;

  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zrun;

  logic [NUM_DIGITS-1:0] an_d;
  logic [3:0]            bcd_d;
  logic                  dp_d;

  // Counter is held at zero whenever not scanning
  assign cnt_clr = (state_q == ST_IDLE) | ~enable;

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV),
    .CW       (CW)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (enable),
    .clr      (cnt_clr),
    .count    (count),
    .slot_end (slot_end)
  );

  assign pend    = ~load_ready;
  assign capture = load_valid & load_ready;
  assign wrap    = (state_q == ST_SHOW) & slot_end
                 & (idx_q == IDX_LAST);
  // Stopped scanning has no boundary to wait for
  assign commit  = pend & (wrap | ~enable);
  assign disp_d  = commit ? shad_q : disp_q;
  assign ddp_d   = commit ? shdp_q : ddp_q;

  // Sanitise offered digits and flag bad ones
  always_comb begin
    clean = '0;
    bad   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      clean[4*i +: 4] = bcd_clean(load_data[4*i +: 4]);
      if (load_data[4*i +: 4] > BCD_MAX) begin
        bad = 1'b1;
      end
    end
  end

  // Next state and digit index
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (enable) begin
          state_d = ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (!enable) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (count == BLANK_LAST) begin
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (!enable) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (slot_end) begin
          state_d = ST_BLANK;
          idx_d   = (idx_q == IDX_LAST)
                  ? '0 : idx_q + IW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Mark zero digits above the top nonzero digit
  always_comb begin
    lz_mask = '0;
    zrun    = lzb;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (zrun && disp_d[4*i +: 4] == 4'd0) begin
        lz_mask[i] = 1'b1;
      end else begin
        zrun = 1'b0;
      end
    end
  end

  // Output values for the state being entered
  always_comb begin
    an_d  = '1;
    bcd_d = BLANK_CODE;
    dp_d  = 1'b1;
    if (state_d == ST_SHOW) begin
      an_d[idx_d] = 1'b0;
      bcd_d = lz_mask[idx_d] ? BLANK_CODE
            : disp_d[{idx_d, 2'b00} +: 4];
      dp_d  = ~ddp_d[idx_d];
    end
  end

  // Scan state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Shadow capture and display commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q     <= '0;
      ddp_q      <= '0;
      shad_q     <= '0;
      shdp_q     <= '0;
      load_ready <= 1'b1;
    end else begin
      disp_q <= disp_d;
      ddp_q  <= ddp_d;
      if (capture) begin
        shad_q     <= clean;
        shdp_q     <= load_dp;
        load_ready <= 1'b0;
      end else if (commit) begin
        load_ready <= 1'b1;
      end
    end
  end

  // Registered display drive and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n       <= '1;
      digit_bcd  <= BLANK_CODE;
      dp_n       <= 1'b1;
      load_err   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      an_n       <= an_d;
      digit_bcd  <= bcd_d;
      dp_n       <= dp_d;
      load_err   <= capture & bad;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with a
// time-based reference model of the scan pattern.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FR = ND * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        lzb = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic [3:0]  load_dp = '0;
  logic        load_ready;
  logic        load_err;
  logic [3:0]  digit_bcd;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        frame_done;

  seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .lzb        (lzb),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .load_ready (load_ready),
    .load_err   (load_err),
    .digit_bcd  (digit_bcd),
    .an_n       (an_n),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: scanning is a function of
  // cycles elapsed since scanning started.
  bit          m_run;
  int          m_t;
  logic [15:0] m_disp;
  logic [3:0]  m_ddp;
  logic [15:0] m_sh;
  logic [3:0]  m_shdp;
  bit          m_pend;
  bit          m_err;
  bit          m_fd;
  bit          m_lzb;

  logic [11:0] obs;

  task automatic m_reset();
    m_run = 0; m_t = 0;
    m_disp = '0; m_ddp = '0;
    m_sh = '0; m_shdp = '0;
    m_pend = 0; m_err = 0; m_fd = 0;
    m_lzb = 0;
  endtask

  function automatic logic [3:0] exp_nib(
    input logic [15:0] d, input int i,
    input bit lz
  );
    int hi;
    logic [3:0] n;
    hi = 0;
    for (int j = 0; j < ND; j++)
      if (d[j*4 +: 4] != 4'd0) hi = j;
    n = d[i*4 +: 4];
    if (lz && i > hi && n == 4'd0) return 4'hF;
    return n;
  endfunction

  function automatic logic [11:0] expv();
    logic [3:0] an, bcd;
    logic dp;
    int d;
    an = 4'hF; bcd = 4'hF; dp = 1'b1;
    if (m_run && (m_t % SD) >= BC) begin
      d   = (m_t / SD) % ND;
      an  = ~(4'b0001 << d);
      bcd = exp_nib(m_disp, d, m_lzb);
      dp  = ~m_ddp[d];
    end
    return {an, bcd, dp, ~m_pend, m_err, m_fd};
  endfunction

  // One clock: update the model from the inputs
  // seen at the edge; return at the falling edge.
  task automatic tick();
    bit bnd, com, cap, bad;
    logic [15:0] san;
    logic [3:0] nib;
    @(posedge clk);
    bnd = m_run && enable && (m_t % FR == FR - 1);
    com = m_pend && (bnd || !enable);
    cap = load_valid && !m_pend;
    bad = 0;
    san = '0;
    for (int i = 0; i < ND; i++) begin
      nib = load_data[i*4 +: 4];
      if (nib > 4'd9) begin
        bad = 1; nib = 4'hF;
      end
      san[i*4 +: 4] = nib;
    end
    m_fd  = bnd;
    m_err = cap && bad;
    if (com) begin
      m_disp = m_sh; m_ddp = m_shdp; m_pend = 0;
    end
    if (cap) begin
      m_sh = san; m_shdp = load_dp; m_pend = 1;
    end
    if (!enable) m_run = 0;
    else if (!m_run) begin m_run = 1; m_t = 0; end
    else m_t++;
    m_lzb = lzb;
    @(negedge clk);
  endtask

  function automatic int an_digit(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Load a value, wait for its commit and record
  // one whole frame of what the display shows.
  task automatic show_frame(
    input  logic [15:0] d,
    input  logic [3:0]  dp,
    output logic [15:0] got,
    output logic [3:0]  gdp,
    output int          nerr,
    output bit          ok
  );
    logic [3:0] seen;
    int dg;
    ok = 0; nerr = 0; got = '1; gdp = '0;
    seen = '0;
    for (int i = 0; i < 100 && !load_ready; i++)
      tick();
    if (!load_ready) return;
    load_valid = 1'b1; load_data = d; load_dp = dp;
    tick();
    load_valid = 1'b0;
    nerr += int'(load_err);
    for (int i = 0; i < 100 && !load_ready; i++) begin
      tick();
      nerr += int'(load_err);
    end
    if (!load_ready) return;
    for (int i = 0; i < FR; i++) begin
      tick();
      nerr += int'(load_err);
      dg = an_digit(an_n);
      if (dg >= 0) begin
        got[dg*4 +: 4] = digit_bcd;
        gdp[dg] = ~dp_n;
        seen[dg] = 1'b1;
      end
    end
    ok = (seen == 4'hF);
  endtask

  task automatic test_reset();
    m_reset();
    rst_n = 1'b0;
    @(negedge clk);
    obs = {an_n, digit_bcd, dp_n,
           load_ready, load_err, frame_done};
    checks++;
    if (obs !== 12'hFFC) begin
      errors++;
      $display("FAIL reset_state got %h exp %h",
               obs, 12'hFFC);
    end
    rst_n = 1'b1;
    tick();
    obs = {an_n, digit_bcd, dp_n,
           load_ready, load_err, frame_done};
    checks++;
    if (obs !== expv()) begin
      errors++;
      $display("FAIL reset_idle got %h exp %h",
               obs, expv());
    end
  endtask

  task automatic test_scan();
    logic [3:0] exp_an [4];
    logic [3:0] exp_bcd [4];
    logic [3:0] s_an [4];
    logic [3:0] s_bcd [4];
    logic [3:0] prev;
    int fd_at [2];
    int nseq, nfd, show0;
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_bcd = '{4'd4, 4'd3, 4'd2, 4'd1};
    nseq = 0; nfd = 0; show0 = 0; prev = 4'hF;
    fd_at = '{0, 0};
    load_valid = 1'b1;
    load_data = 16'h1234;
    load_dp = 4'b0100;
    tick();
    load_valid = 1'b0;
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL scan_pending got %b exp 0",
               load_ready);
    end
    tick();
    enable = 1'b1;
    for (int c = 0; c < 70; c++) begin
      tick();
      obs = {an_n, digit_bcd, dp_n,
             load_ready, load_err, frame_done};
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL scan_cyc%0d got %h exp %h",
                 c, obs, expv());
      end
      if (an_n != 4'hF && prev == 4'hF && nseq < 4) begin
        s_an[nseq] = an_n;
        s_bcd[nseq] = digit_bcd;
        nseq++;
      end
      if (c < FR && an_n == 4'b1110) show0++;
      if (frame_done && nfd < 2) begin
        fd_at[nfd] = c;
        nfd++;
      end
      prev = an_n;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= nseq || s_an[k] !== exp_an[k] ||
          s_bcd[k] !== exp_bcd[k]) begin
        errors++;
        $display("FAIL scan_seq%0d got %b/%h exp %b/%h",
                 k, s_an[k], s_bcd[k],
                 exp_an[k], exp_bcd[k]);
      end
    end
    checks++;
    if (show0 != SD - BC) begin
      errors++;
      $display("FAIL scan_show_len got %0d exp %0d",
               show0, SD - BC);
    end
    checks++;
    if (nfd < 2 || fd_at[0] != FR ||
        fd_at[1] - fd_at[0] != FR) begin
      errors++;
      $display("FAIL scan_frame_done got %0d,%0d exp %0d,%0d",
               fd_at[0], fd_at[1], FR, 2 * FR);
    end
  endtask

  task automatic test_handshake();
    bit rdy, cap;
    int phase;
    load_dp = 4'b0000;
    load_valid = 1'b1;
    load_data = 16'h0005;
    tick();
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL hs_first_capture got %b exp 0",
               load_ready);
    end
    load_data = 16'h0009;
    cap = 0;
    for (int c = 0; c < 80 && !cap; c++) begin
      rdy = load_ready;
      tick();
      obs = {an_n, digit_bcd, dp_n,
             load_ready, load_err, frame_done};
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL hs_stall%0d got %h exp %h",
                 c, obs, expv());
      end
      cap = rdy;
    end
    load_valid = 1'b0;
    checks++;
    if (!cap) begin
      errors++;
      $display("FAIL hs_second_capture got none exp capture");
    end
    phase = 0;
    for (int c = 0; c < 80 && phase < 3; c++) begin
      tick();
      if (phase == 0 && an_n == 4'b1110) begin
        checks++;
        if (digit_bcd !== 4'd5) begin
          errors++;
          $display("FAIL hs_show_first got %h exp 5",
                   digit_bcd);
        end
        phase = 1;
      end else if (phase == 1 && frame_done) begin
        phase = 2;
      end else if (phase == 2 && an_n == 4'b1110) begin
        checks++;
        if (digit_bcd !== 4'd9) begin
          errors++;
          $display("FAIL hs_show_second got %h exp 9",
                   digit_bcd);
        end
        phase = 3;
      end
    end
    checks++;
    if (phase != 3) begin
      errors++;
      $display("FAIL hs_timeout got phase %0d exp 3",
               phase);
    end
  endtask

  task automatic test_invalid_bcd();
    logic [15:0] got;
    logic [3:0] gdp;
    int nerr;
    bit ok;
    show_frame(16'h12A4, 4'b0000, got, gdp, nerr, ok);
    checks++;
    if (!ok || got !== 16'h12F4) begin
      errors++;
      $display("FAIL bcd_digits got %h ok %0d exp 12f4",
               got, ok);
    end
    checks++;
    if (nerr != 1) begin
      errors++;
      $display("FAIL bcd_err_pulses got %0d exp 1",
               nerr);
    end
  endtask

  task automatic test_lzb();
    logic [15:0] got;
    logic [3:0] gdp;
    int nerr;
    bit ok;
    lzb = 1'b1;
    show_frame(16'h0040, 4'b0000, got, gdp, nerr, ok);
    checks++;
    if (!ok || got !== 16'hFF40) begin
      errors++;
      $display("FAIL lzb_0040 got %h ok %0d exp ff40",
               got, ok);
    end
    show_frame(16'h0000, 4'b1000, got, gdp, nerr, ok);
    checks++;
    if (!ok || got !== 16'hFFF0) begin
      errors++;
      $display("FAIL lzb_0000 got %h ok %0d exp fff0",
               got, ok);
    end
    checks++;
    if (gdp !== 4'b1000) begin
      errors++;
      $display("FAIL lzb_dp got %b exp 1000", gdp);
    end
    checks++;
    if (nerr != 0) begin
      errors++;
      $display("FAIL lzb_err got %0d exp 0", nerr);
    end
    lzb = 1'b0;
  endtask

  task automatic test_enable_reset();
    bit found;
    found = 0;
    for (int c = 0; c < 80 && !found; c++) begin
      tick();
      found = (an_n == 4'b1011);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL en_find_digit2 got %b exp 1011",
               an_n);
    end
    enable = 1'b0;
    tick();
    checks++;
    if (an_n !== 4'hF) begin
      errors++;
      $display("FAIL en_drop got %b exp 1111", an_n);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      obs = {an_n, digit_bcd, dp_n,
             load_ready, load_err, frame_done};
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL en_idle%0d got %h exp %h",
                 c, obs, expv());
      end
    end
    enable = 1'b1;
    for (int c = 0; c < BC + 1; c++) begin
      tick();
      checks++;
      if (c < BC && {an_n, digit_bcd} !== 8'hFF) begin
        errors++;
        $display("FAIL en_restart_blank%0d got %h exp ff",
                 c, {an_n, digit_bcd});
      end else if (c == BC && an_n !== 4'b1110) begin
        errors++;
        $display("FAIL en_restart_digit0 got %b exp 1110",
                 an_n);
      end
    end
    for (int c = 0; c < 13; c++) tick();
    load_valid = 1'b1;
    load_data = 16'h7777;
    tick();
    load_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    obs = {an_n, digit_bcd, dp_n,
           load_ready, load_err, frame_done};
    checks++;
    if (obs !== 12'hFFC) begin
      errors++;
      $display("FAIL rst_async got %h exp %h",
               obs, 12'hFFC);
    end
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      obs = {an_n, digit_bcd, dp_n,
             load_ready, load_err, frame_done};
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL rst_resume%0d got %h exp %h",
                 c, obs, expv());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      enable = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 49) == 0) lzb = ~lzb;
      load_valid = ($urandom_range(0, 7) == 0);
      load_data = 16'($urandom);
      load_dp = 4'($urandom);
      tick();
      obs = {an_n, digit_bcd, dp_n,
             load_ready, load_err, frame_done};
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL rand%0d got %h exp %h",
                 c, obs, expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_handshake();
    test_invalid_bcd();
    test_lzb();
    test_enable_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
